dual_channel_receiver: RTL and testbench

Downstream consumer for the two-channel processor sender. It terminates both `send`/`ack` handshakes and captures each word once per handshake. It merges the words from both channels into one shared FIFO using round-robin arbitration. It presents that FIFO as a valid/ready stream tagged with the source channel.

---
 rtl/dual_channel_receiver_if.sv | 28 ++
 rtl/dual_channel_receiver.sv | 124 ++++++++++++
 tb/tb_dual_channel_receiver.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dual_channel_receiver_if.sv
// Bundles the two send/ack channels and the tagged output stream of the receiver.
// The master side is the sender/consumer environment and the slave side is the receiver.
interface dual_channel_receiver_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
);
    logic [WIDTH-1:0]         data1;
    logic                     send1;
    logic                     ack1;
    logic [WIDTH-1:0]         data2;
    logic                     send2;
    logic                     ack2;
    logic [WIDTH-1:0]         out_data;
    logic                     out_chan;
    logic                     out_valid;
    logic                     out_ready;
    logic [$clog2(DEPTH):0]   fifo_count;

    modport master (
        output data1, send1, data2, send2, out_ready,
        input  ack1, ack2, out_data, out_chan, out_valid, fifo_count
    );

    modport slave (
        input  data1, send1, data2, send2, out_ready,
        output ack1, ack2, out_data, out_chan, out_valid, fifo_count
    );
endinterface

// File: rtl/dual_channel_receiver.sv
// Two-channel four-phase handshake receiver.
// Each channel captures one word per send/ack handshake. A round-robin arbiter
// merges both channels into one shared FIFO, presented as a show-ahead
// valid/ready stream tagged with the source channel.
module dual_channel_receiver #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    dual_channel_receiver_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACKING = 1'b1;

    logic [0:0]    state1;
    logic [0:0]    state2;
    logic          req1;
    logic          req2;
    logic          grant1;
    logic          grant2;
    logic          write_ok;
    logic          prefer2;
    logic          push;
    logic          pop;
    logic [WIDTH:0] wr_entry;

    logic [WIDTH:0]  mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    // A channel only requests from IDLE, so a word already acknowledged is
    // never captured a second time while its sender lowers send.
    assign req1 = (state1 == IDLE) && bus.send1;
    assign req2 = (state2 == IDLE) && bus.send2;

    // Space is judged on the count at the start of the cycle; a pop in the
    // same cycle does not make room for this cycle's write.
    assign write_ok = (count < FULL_COUNT);

    // prefer2 is set once channel 1 has been granted, so under contention the
    // channel not granted most recently wins.
    assign grant1 = write_ok && req1 && (!req2 || !prefer2);
    assign grant2 = write_ok && req2 && (!req1 ||  prefer2);

    assign push     = grant1 || grant2;
    assign pop      = (count != '0) && bus.out_ready;
    assign wr_entry = grant1 ? {1'b0, bus.data1} : {1'b1, bus.data2};

    // The acknowledge is the registered ACKING state itself.
    assign bus.ack1       = (state1 == ACKING);
    assign bus.ack2       = (state2 == ACKING);
    assign bus.out_valid  = (count != '0);
    assign bus.out_data   = mem[rd_ptr][WIDTH-1:0];
    assign bus.out_chan   = mem[rd_ptr][WIDTH];
    assign bus.fifo_count = count;

    // Channel 1 handshake: enter ACKING on a grant, leave once send1 is seen low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state1 <= IDLE;
        end else begin
            case (state1)
                IDLE:    if (grant1)     state1 <= ACKING;
                ACKING:  if (!bus.send1) state1 <= IDLE;
                default: state1 <= IDLE;
            endcase
        end
    end

    // Channel 2 handshake: enter ACKING on a grant, leave once send2 is seen low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state2 <= IDLE;
        end else begin
            case (state2)
                IDLE:    if (grant2)     state2 <= ACKING;
                ACKING:  if (!bus.send2) state2 <= IDLE;
                default: state2 <= IDLE;
            endcase
        end
    end

    // Round-robin pointer moves only when a grant actually happens.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prefer2 <= 1'b0;
        end else if (grant1) begin
            prefer2 <= 1'b1;
        end else if (grant2) begin
            prefer2 <= 1'b0;
        end
    end

    // Storage array holds no control state, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two; the count is
    // unchanged when a push and a pop coincide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_dual_channel_receiver.sv
// Scoreboard bench for dual_channel_receiver: stimulus pushes the hand-computed
// expected {chan, data} words into a queue, and a monitor pops and compares
// whenever the receiver hands a word to the consumer.
module tb_dual_channel_receiver;
    localparam int WIDTH = 16;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    dual_channel_receiver_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus();

    dual_channel_receiver #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [WIDTH:0] expQ [$];
    int checks   = 0;
    int errors   = 0;
    int popCount = 0;
    int popBase  = 0;

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    function automatic logic ackOf(input int ch);
        return (ch == 1) ? bus.ack1 : bus.ack2;
    endfunction

    task automatic setSend(input int ch, input logic val);
        if (ch == 1) bus.send1 = val;
        else         bus.send2 = val;
    endtask

    // One complete four-phase handshake on a channel, as the sender performs it.
    task automatic applyStimulus(input int ch, input logic [WIDTH-1:0] word);
        int n;
        if (ch == 1) bus.data1 = word;
        else         bus.data2 = word;
        setSend(ch, 1'b1);
        n = 0;
        while (ackOf(ch) !== 1'b1 && n < 50) begin
            tick(1);
            n++;
        end
        checkOutput("ack_rise_seen", 32'(ackOf(ch)), 32'd1);
        setSend(ch, 1'b0);
        n = 0;
        while (ackOf(ch) !== 1'b0 && n < 50) begin
            tick(1);
            n++;
        end
        checkOutput("ack_fall_seen", 32'(ackOf(ch)), 32'd0);
    endtask

    task automatic waitAckLow(input int ch, input string name);
        int n;
        n = 0;
        while (ackOf(ch) !== 1'b0 && n < 20) begin
            tick(1);
            n++;
        end
        checkOutput(name, 32'(ackOf(ch)), 32'd0);
    endtask

    task automatic drain();
        int n;
        bus.out_ready = 1'b1;
        n = 0;
        while ((bus.out_valid === 1'b1 || expQ.size() != 0) && n < 100) begin
            tick(1);
            n++;
        end
        checkOutput("drain_queue_empty", 32'(expQ.size()), 32'd0);
        checkOutput("drain_out_valid", 32'(bus.out_valid), 32'd0);
    endtask

    task automatic resetDut();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        expQ.delete();
        tick(1);
    endtask

    // Monitor: every accepted head word must be the next expected one.
    task automatic monitorLoop();
        logic [WIDTH:0] expWord;
        forever begin
            @(negedge clk);
            if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                popCount++;
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_word actual=%0h expected=none",
                             {bus.out_chan, bus.out_data});
                end else begin
                    expWord = expQ.pop_front();
                    checkOutput("stream_word", 32'({bus.out_chan, bus.out_data}), 32'(expWord));
                end
            end
        end
    endtask

    initial begin
        int n;
        bus.data1 = '0;
        bus.data2 = '0;
        bus.send1 = 1'b0;
        bus.send2 = 1'b0;
        bus.out_ready = 1'b0;
        fork
            monitorLoop();
        join_none

        // Reset state
        tick(2);
        checkOutput("reset_ack1", 32'(bus.ack1), 32'd0);
        checkOutput("reset_ack2", 32'(bus.ack2), 32'd0);
        checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset_count", 32'(bus.fifo_count), 32'd0);
        rst = 1'b0;
        tick(1);

        // Single word on channel 1
        $display("[TB] single word");
        popBase = popCount;
        bus.out_ready = 1'b1;
        expQ.push_back({1'b0, 16'hA5A5});
        bus.data1 = 16'hA5A5;
        bus.send1 = 1'b1;
        tick(1);
        checkOutput("single_ack1_rise", 32'(bus.ack1), 32'd1);
        checkOutput("single_out_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("single_out_chan", 32'(bus.out_chan), 32'd0);
        checkOutput("single_out_data", 32'(bus.out_data), 32'hA5A5);
        checkOutput("single_count", 32'(bus.fifo_count), 32'd1);
        bus.send1 = 1'b0;
        tick(1);
        checkOutput("single_valid_one_cycle", 32'(bus.out_valid), 32'd0);
        checkOutput("single_count_after_pop", 32'(bus.fifo_count), 32'd0);
        waitAckLow(1, "single_ack1_fall");
        tick(3);
        checkOutput("single_one_delivery", 32'(popCount - popBase), 32'd1);

        // Contention: channel 1 first after reset, then the round robin alternates
        $display("[TB] contention");
        resetDut();
        bus.out_ready = 1'b0;
        expQ.push_back({1'b0, 16'h0001});
        expQ.push_back({1'b1, 16'h0002});
        bus.data1 = 16'h0001;
        bus.data2 = 16'h0002;
        bus.send1 = 1'b1;
        bus.send2 = 1'b1;
        tick(1);
        checkOutput("cont_ack1_first", 32'(bus.ack1), 32'd1);
        checkOutput("cont_ack2_waits", 32'(bus.ack2), 32'd0);
        checkOutput("cont_count1", 32'(bus.fifo_count), 32'd1);
        bus.send1 = 1'b0;
        tick(1);
        checkOutput("cont_ack2_next", 32'(bus.ack2), 32'd1);
        checkOutput("cont_count2", 32'(bus.fifo_count), 32'd2);
        bus.send2 = 1'b0;
        waitAckLow(2, "cont_ack2_fall");
        drain();
        expQ.push_back({1'b0, 16'h0003});
        applyStimulus(1, 16'h0003);
        expQ.push_back({1'b1, 16'h0006});
        expQ.push_back({1'b0, 16'h0005});
        bus.data1 = 16'h0005;
        bus.data2 = 16'h0006;
        bus.send1 = 1'b1;
        bus.send2 = 1'b1;
        tick(1);
        checkOutput("cont2_ack2_wins", 32'(bus.ack2), 32'd1);
        checkOutput("cont2_ack1_waits", 32'(bus.ack1), 32'd0);
        bus.send2 = 1'b0;
        tick(1);
        checkOutput("cont2_ack1_next", 32'(bus.ack1), 32'd1);
        bus.send1 = 1'b0;
        waitAckLow(1, "cont2_ack1_fall");
        waitAckLow(2, "cont2_ack2_fall");
        drain();

        // Backpressure: both channels stream into a stalled FIFO
        $display("[TB] backpressure");
        resetDut();
        bus.out_ready = 1'b0;
        expQ.push_back({1'b0, 16'h0010});
        expQ.push_back({1'b1, 16'h0020});
        expQ.push_back({1'b0, 16'h0011});
        expQ.push_back({1'b1, 16'h0021});
        expQ.push_back({1'b0, 16'h0012});
        expQ.push_back({1'b1, 16'h0022});
        fork
            begin
                applyStimulus(1, 16'h0010);
                applyStimulus(1, 16'h0011);
                applyStimulus(1, 16'h0012);
            end
            begin
                applyStimulus(2, 16'h0020);
                applyStimulus(2, 16'h0021);
                applyStimulus(2, 16'h0022);
            end
            begin
                int m;
                m = 0;
                while (bus.fifo_count !== 3'd4 && m < 50) begin
                    tick(1);
                    m++;
                end
                checkOutput("bp_reaches_full", 32'(bus.fifo_count), 32'd4);
                tick(2);
                checkOutput("bp_full_holds", 32'(bus.fifo_count), 32'd4);
                checkOutput("bp_ack1_stalled", 32'(bus.ack1), 32'd0);
                checkOutput("bp_ack2_stalled", 32'(bus.ack2), 32'd0);
                bus.out_ready = 1'b1;
                tick(1);
                bus.out_ready = 1'b0;
                checkOutput("bp_pop_count", 32'(bus.fifo_count), 32'd3);
                checkOutput("bp_no_same_cycle_write", 32'(bus.ack1), 32'd0);
                tick(1);
                checkOutput("bp_blocked_captured", 32'(bus.ack1), 32'd1);
                checkOutput("bp_other_still_waits", 32'(bus.ack2), 32'd0);
                checkOutput("bp_refilled", 32'(bus.fifo_count), 32'd4);
                bus.out_ready = 1'b1;
            end
        join
        drain();

        // Pointer wrap: continuous push and pop with a steady count
        $display("[TB] pointer wrap");
        resetDut();
        popBase = popCount;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            expQ.push_back({1'b0, 16'(16'h0030 + i)});
            expQ.push_back({1'b1, 16'(16'h0040 + i)});
        end
        fork
            begin
                for (int i = 0; i < 5; i++) applyStimulus(1, 16'(16'h0030 + i));
            end
            begin
                for (int i = 0; i < 5; i++) applyStimulus(2, 16'(16'h0040 + i));
            end
            begin
                int m;
                m = 0;
                while (bus.fifo_count !== 3'd1 && m < 50) begin
                    tick(1);
                    m++;
                end
                for (int k = 0; k < 8; k++) begin
                    tick(1);
                    checkOutput("wrap_count_steady", 32'(bus.fifo_count), 32'd1);
                end
            end
        join
        drain();
        checkOutput("wrap_ten_words", 32'(popCount - popBase), 32'd10);

        // Reset in the middle of a channel 2 handshake
        $display("[TB] reset mid-handshake");
        resetDut();
        bus.out_ready = 1'b0;
        expQ.push_back({1'b0, 16'h0050});
        expQ.push_back({1'b0, 16'h0051});
        applyStimulus(1, 16'h0050);
        applyStimulus(1, 16'h0051);
        bus.data2 = 16'h0060;
        bus.send2 = 1'b1;
        tick(1);
        checkOutput("mid_ack2_high", 32'(bus.ack2), 32'd1);
        checkOutput("mid_count3", 32'(bus.fifo_count), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("mid_async_ack2", 32'(bus.ack2), 32'd0);
        checkOutput("mid_async_ack1", 32'(bus.ack1), 32'd0);
        checkOutput("mid_async_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("mid_async_count", 32'(bus.fifo_count), 32'd0);
        expQ.delete();
        expQ.push_back({1'b1, 16'h0060});
        popBase = popCount;
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("mid_recapture_ack2", 32'(bus.ack2), 32'd1);
        checkOutput("mid_recapture_count", 32'(bus.fifo_count), 32'd1);
        bus.send2 = 1'b0;
        waitAckLow(2, "mid_ack2_fall");
        tick(2);
        checkOutput("mid_captured_once", 32'(bus.fifo_count), 32'd1);
        drain();
        checkOutput("mid_one_delivery", 32'(popCount - popBase), 32'd1);

        // Ready while empty must not pop or move the read pointer
        $display("[TB] idle ready");
        popBase = popCount;
        bus.out_ready = 1'b1;
        tick(3);
        checkOutput("idle_count", 32'(bus.fifo_count), 32'd0);
        checkOutput("idle_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("idle_no_pop", 32'(popCount - popBase), 32'd0);
        expQ.push_back({1'b1, 16'h0070});
        applyStimulus(2, 16'h0070);
        drain();
        checkOutput("idle_then_one", 32'(popCount - popBase), 32'd1);

        n = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
